// File: rtl/peri_timer_pkg.sv
// Shared definitions for the peripheral-bus machine timer.
// Register word indices, CTRL bit positions, CTRL layout and a byte-merge helper.
package peri_timer_pkg;

    // Word index = addr[5:2] inside the 64-byte slot
    localparam logic [3:0] REG_MTIME_LO = 4'h0;
    localparam logic [3:0] REG_MTIME_HI = 4'h1;
    localparam logic [3:0] REG_CMP_LO   = 4'h2;
    localparam logic [3:0] REG_CMP_HI   = 4'h3;
    localparam logic [3:0] REG_CTRL     = 4'h4;
    localparam logic [3:0] REG_STATUS   = 4'h5;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_IE_BIT    = 1;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MAX = 24;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Mirrors the CTRL register image bit for bit
    typedef struct packed {
        logic [CTRL_PRESC_MAX-1:0] presc;
        logic [5:0]                rsvd;
        logic                      ie;
        logic                      en;
    } ctrl_t;

    // Replace only the bytes selected by be
    function automatic logic [31:0] be_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/peri_timer_if.sv
// Core-complex peripheral bus: req/gnt request phase, rvalid/rdata response.
// Ports: master drives req/addr/write/be/wdata; slave drives gnt/rvalid/rdata.
interface peri_timer_if;

    logic        peri_req;
    logic [31:0] peri_addr;
    logic        peri_write;
    logic [3:0]  peri_be;
    logic [31:0] peri_wdata;
    logic        peri_gnt;
    logic        peri_rvalid;
    logic [31:0] peri_rdata;

    modport master (
        output peri_req,
        output peri_addr,
        output peri_write,
        output peri_be,
        output peri_wdata,
        input  peri_gnt,
        input  peri_rvalid,
        input  peri_rdata
    );

    modport slave (
        input  peri_req,
        input  peri_addr,
        input  peri_write,
        input  peri_be,
        input  peri_wdata,
        output peri_gnt,
        output peri_rvalid,
        output peri_rdata
    );

endinterface

// File: rtl/peri_timer_presc.sv
// Timer prescaler: pcnt counts 0..presc while en, tick pulses at pcnt==presc.
// Ports: clk, rst_n, en (freeze when 0), clr (sync clear), presc, tick.
module peri_timer_presc #(
    parameter int PrescW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [PrescW-1:0] presc,
    output logic              tick
);

    logic [PrescW-1:0] pcnt_q;

    assign tick = en & (pcnt_q == presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (clr) begin
            pcnt_q <= '0;
        end else if (tick) begin
            pcnt_q <= '0;
        end else if (en) begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/peri_timer.sv
// RISC-V machine timer on the peripheral bus: mtime, mtimecmp, CTRL, STATUS.
// Ports: clk, rst_n, bus (peri_timer_if.slave), irq_timer_o (level irq).
// Build option PERI_TIMER_HI_LATCH_EN: MTIME_HI reads a shadow latched by LO reads.
module peri_timer
    import peri_timer_pkg::*;
#(
    parameter logic [31:0] BaseOffset = 32'h0000_0000,
    parameter int          PrescW     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    peri_timer_if.slave  bus,
    output logic         irq_timer_o
);

    localparam logic [CTRL_PRESC_MAX-1:0] PrescMask =
        (CTRL_PRESC_MAX'(1) << PrescW) - CTRL_PRESC_MAX'(1);
    localparam logic [31:0] CtrlMask = {PrescMask, 6'b0, 2'b11};

    logic        hit;
    logic        wr;
    logic        rd;
    logic [3:0]  idx;
    logic        we_lo;
    logic        we_hi;
    logic        ctrl_wr;
    logic        tick;

    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] cmp_q;
    logic [63:0] cmp_d;
    ctrl_t       ctrl_q;
    ctrl_t       ctrl_d;

    logic [31:0] hi_rd;
    logic [31:0] rd_word;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        irq_q;

    logic        unused_addr;
    assign unused_addr = ^bus.peri_addr[1:0];

    // Whole 64-byte slot decodes to this block
    assign hit = bus.peri_req
               & (bus.peri_addr[31:6] == BaseOffset[31:6]);
    assign idx = bus.peri_addr[5:2];
    assign wr  = hit & bus.peri_write;
    assign rd  = hit & ~bus.peri_write;

    assign we_lo   = wr & (idx == REG_MTIME_LO);
    assign we_hi   = wr & (idx == REG_MTIME_HI);
    assign ctrl_wr = wr & (idx == REG_CTRL);

    assign bus.peri_gnt    = bus.peri_req & rst_n;
    assign bus.peri_rvalid = rvalid_q;
    assign bus.peri_rdata  = rdata_q;
    assign irq_timer_o     = irq_q;

    peri_timer_presc #(
        .PrescW (PrescW)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (ctrl_q.en),
        .clr    (ctrl_wr),
        .presc  (ctrl_q.presc[PrescW-1:0]),
        .tick   (tick)
    );

    // Bus write to either mtime half beats the tick; the
    // increment is one 64-bit add so LO->HI carry is atomic.
    always_comb begin
        mtime_d = mtime_q;
        priority case (1'b1)
            we_lo: begin
                mtime_d[31:0] = be_merge(mtime_q[31:0],
                    bus.peri_wdata, bus.peri_be);
            end
            we_hi: begin
                mtime_d[63:32] = be_merge(mtime_q[63:32],
                    bus.peri_wdata, bus.peri_be);
            end
            tick: begin
                mtime_d = mtime_q + 64'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        cmp_d  = cmp_q;
        ctrl_d = ctrl_q;
        if (wr && idx == REG_CMP_LO) begin
            cmp_d[31:0] = be_merge(cmp_q[31:0],
                bus.peri_wdata, bus.peri_be);
        end
        if (wr && idx == REG_CMP_HI) begin
            cmp_d[63:32] = be_merge(cmp_q[63:32],
                bus.peri_wdata, bus.peri_be);
        end
        if (ctrl_wr) begin
            ctrl_d = ctrl_t'(be_merge(ctrl_q,
                bus.peri_wdata, bus.peri_be) & CtrlMask);
        end
    end

`ifdef PERI_TIMER_HI_LATCH_EN
    logic [31:0] shadow_q;

    // LO read snapshots the upper half so LO-then-HI is coherent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (rd && idx == REG_MTIME_LO) begin
            shadow_q <= mtime_q[63:32];
        end
    end

    assign hi_rd = shadow_q;
`else
    assign hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        rd_word = '0;
        unique case (idx)
            REG_MTIME_LO: rd_word = mtime_q[31:0];
            REG_MTIME_HI: rd_word = hi_rd;
            REG_CMP_LO:   rd_word = cmp_q[31:0];
            REG_CMP_HI:   rd_word = cmp_q[63:32];
            REG_CTRL:     rd_word = ctrl_q;
            REG_STATUS:   rd_word = {31'b0, mtime_q >= cmp_q};
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q  <= '0;
            cmp_q    <= MTIMECMP_RST;
            ctrl_q   <= '0;
            irq_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            // Compare uses the values this cycle is writing
            irq_q    <= ctrl_d.ie & (mtime_d >= cmp_d);
            rvalid_q <= bus.peri_req;
            rdata_q  <= rd ? rd_word : 32'h0;
        end
    end

endmodule

// File: tb/tb_peri_timer.sv
// Directed bench for peri_timer: bus handshake, counting, compare irq,
// wrap/carry, write-vs-tick priority, unmapped/out-of-slot access, reset.
module tb_peri_timer;

    logic clk = 1'b0;
    logic rst_n;
    logic irq;

    always #5 clk = ~clk;

    peri_timer_if bus ();

    peri_timer #(
        .BaseOffset (32'h0000_0000),
        .PrescW     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .irq_timer_o (irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic xfer(input string tag,
                        input logic w,
                        input logic [31:0] a,
                        input logic [3:0] be,
                        input logic [31:0] d,
                        output logic [31:0] rd);
        bus.peri_req   = 1'b1;
        bus.peri_write = w;
        bus.peri_addr  = a;
        bus.peri_be    = be;
        bus.peri_wdata = d;
        #1;
        chk({tag, "_gnt"}, 32'(bus.peri_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.peri_req   = 1'b0;
        bus.peri_write = 1'b0;
        chk({tag, "_rv"}, 32'(bus.peri_rvalid), 32'd1);
        rd = bus.peri_rdata;
        @(negedge clk);
    endtask

    task automatic wr32(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] be = 4'hF);
        logic [31:0] r;
        xfer(tag, 1'b1, a, be, d, r);
        chk({tag, "_wdat"}, r, 32'h0);
    endtask

    task automatic rd32(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
        logic [31:0] r;
        xfer(tag, 1'b0, a, 4'h0, 32'h0, r);
        chk(tag, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.peri_req   = 1'b1;
        bus.peri_write = 1'b0;
        bus.peri_addr  = '0;
        bus.peri_be    = '0;
        bus.peri_wdata = '0;
        rst_n          = 1'b0;
        #12;
        chk("rst_gnt", 32'(bus.peri_gnt), 32'd0);
        chk("rst_rv", 32'(bus.peri_rvalid), 32'd0);
        chk("rst_rdata", bus.peri_rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        bus.peri_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        rd32("r_lo", 32'h00, 32'h0);
        rd32("r_cmphi", 32'h0C, 32'hFFFF_FFFF);
        rd32("r_ctrl", 32'h10, 32'h0);
        chk("r_irq", 32'(irq), 32'd0);

        // PRESC=3: first tick 4 clocks after the CTRL write
        wr32("t2_ctrl", 32'h10, 32'h0000_0301);
        idle(40);
        begin
            logic [31:0] r;
            xfer("t2_lo", 1'b0, 32'h00, 4'h0, 32'h0, r);
            chk("t2_lo_range", 32'(r >= 9 && r <= 11), 32'd1);
        end
        rd32("t2_ctrl_rd", 32'h10, 32'h0000_0301);
        wr32("t2_dis", 32'h10, 32'h0);
        wr32("t2_lo", 32'h00, 32'h55);
        wr32("t2_hi", 32'h04, 32'h0);
        idle(5);
        rd32("t2_frozen", 32'h00, 32'h55);

        // Compare irq, PRESC=0
        wr32("t3_lo", 32'h00, 32'h0);
        wr32("t3_cmph", 32'h0C, 32'h0);
        wr32("t3_cmpl", 32'h08, 32'h5);
        wr32("t3_ctrl", 32'h10, 32'h0000_0003);
        chk("t3_irq0", 32'(irq), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("t3_irq%0d", i), 32'(irq),
                32'(i == 5));
        end
        wr32("t3_cmp100", 32'h08, 32'd100);
        chk("t3_irq_clr", 32'(irq), 32'd0);
        wr32("t3_dis", 32'h10, 32'h0);

        // 32-bit carry into HI
        wr32("t4_hi", 32'h04, 32'h0);
        wr32("t4_lo", 32'h00, 32'hFFFF_FFFF);
        wr32("t4_ctrl", 32'h10, 32'h0000_FF01);
        idle(256);
        wr32("t4_dis", 32'h10, 32'h0);
        rd32("t4_lo_rd", 32'h00, 32'h0);
        rd32("t4_hi_rd", 32'h04, 32'h1);

        // 64-bit wrap
        wr32("t4w_lo", 32'h00, 32'hFFFF_FFFF);
        wr32("t4w_hi", 32'h04, 32'hFFFF_FFFF);
        wr32("t4w_ctrl", 32'h10, 32'h0000_FF01);
        idle(256);
        wr32("t4w_dis", 32'h10, 32'h0);
        rd32("t4w_lo_rd", 32'h00, 32'h0);
        rd32("t4w_hi_rd", 32'h04, 32'h0);

        // PRESC=1: tick lands two cycles after CTRL write,
        // exactly where the partial LO write is sampled
        wr32("t5_hi", 32'h04, 32'h77);
        wr32("t5_lo", 32'h00, 32'hAABB_CCDD);
        wr32("t5_ctrl", 32'h10, 32'h0000_0101);
        idle(1);
        wr32("t5_be", 32'h00, 32'hFFFF_1234, 4'b0011);
        wr32("t5_dis", 32'h10, 32'h0);
        rd32("t5_lo_rd", 32'h00, 32'hAABB_1234);
        rd32("t5_hi_rd", 32'h04, 32'h77);

        // Back-to-back to unmapped offset
        rd32("t6_rd0", 32'h20, 32'h0);
        wr32("t6_wr", 32'h20, 32'hDEAD_BEEF);
        rd32("t6_rd1", 32'h20, 32'h0);
        @(posedge clk);
        #1;
        chk("t6_rv_drop", 32'(bus.peri_rvalid), 32'd0);
        @(negedge clk);
        rd32("t6_cmpl", 32'h08, 32'd100);
        rd32("t6_cmph", 32'h0C, 32'h0);
        rd32("t6_status", 32'h14, 32'h1);
        wr32("t6_out_wr", 32'h40, 32'h0);
        rd32("t6_out_rd", 32'h40, 32'h0);
        rd32("t6_lo_keep", 32'h00, 32'hAABB_1234);

`ifdef PERI_TIMER_HI_LATCH_EN
        wr32("hl_hi", 32'h04, 32'h1);
        wr32("hl_lo", 32'h00, 32'hFFFF_FFFF);
        wr32("hl_ctrl", 32'h10, 32'h0000_FF01);
        rd32("hl_lo_rd", 32'h00, 32'hFFFF_FFFF);
        idle(256);
        rd32("hl_hi_rd", 32'h04, 32'h1);
        wr32("hl_dis", 32'h10, 32'h0);
`endif

        // Reset with a response in flight
        bus.peri_req   = 1'b1;
        bus.peri_write = 1'b0;
        bus.peri_addr  = 32'h04;
        @(posedge clk);
        #1;
        chk("rm_rv", 32'(bus.peri_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rm_rv_drop", 32'(bus.peri_rvalid), 32'd0);
        chk("rm_rdata", bus.peri_rdata, 32'h0);
        chk("rm_gnt", 32'(bus.peri_gnt), 32'd0);
        bus.peri_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
